vvm_phase_avg: RTL and testbench

Downstream consumer of the vvm_dsp result stream. It deserializes each frame of per-channel magnitude/phase words and computes the phase of channels 1..N_CH-1 relative to channel 0, with modulo-2π wrap. It then smooths magnitudes and relative phases with a wrap-aware first-order IIR and presents the results as parallel registers with a one-cycle valid pulse for the register bank / CSR readout.

---
 rtl/vvm_pkg.sv | 22 ++
 rtl/wrap_iir_step.sv | 35 +++
 rtl/vvm_phase_avg.sv | 150 +++++++++++++++
 tb/tb_vvm_phase_avg.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vvm_pkg.sv
// Shared definitions for the vvm result-stream consumers: FSM encoding,
// IIR fraction default and the modulo-2^DW phase subtraction.
package vvm_pkg;

    localparam int VVM_DW     = 21;
    localparam int W_FRAC_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } fsm_state_t;

    // Phase words are fractions of a full turn, so plain two's-complement
    // wrap of the difference is exactly the modulo-2pi relative phase.
    function automatic logic [VVM_DW-1:0] wrap_sub(input logic [VVM_DW-1:0] a,
                                                   input logic [VVM_DW-1:0] b);
        return a - b;
    endfunction

endpackage

// File: rtl/wrap_iir_step.sv
// One first-order IIR update, shared by all lanes: s += (x*2^W_FRAC - s) >>> k.
// Phase lanes wrap the error term so averaging across +/-pi stays on the short arc.
module wrap_iir_step
    import vvm_pkg::*;
#(
    parameter int DW     = VVM_DW,
    parameter int W_FRAC = W_FRAC_DEF
) (
    input  logic signed [DW-1:0]        x,
    input  logic signed [DW+W_FRAC-1:0] s,
    input  logic        [3:0]           k,
    input  logic                        is_phase,
    input  logic                        seed,
    output logic signed [DW+W_FRAC-1:0] s_next
);

    localparam int SW = DW + W_FRAC;

    logic signed [SW-1:0] xs;
    logic signed [SW:0]   diff_full;
    logic signed [SW:0]   diff;
    logic signed [SW:0]   step;
    logic        [3:0]    k_eff;

    always_comb begin
        xs        = {x, {W_FRAC{1'b0}}};
        k_eff     = (int'(k) > W_FRAC) ? 4'(W_FRAC) : k;
        diff_full = {xs[SW-1], xs} - {s[SW-1], s};
        // magnitude keeps the full-width error; phase reduces it modulo 2^SW
        diff      = is_phase ? {diff_full[SW-1], diff_full[SW-1:0]} : diff_full;
        step      = diff >>> k_eff;
        s_next    = seed ? xs : SW'({s[SW-1], s} + step);
    end

endmodule

// File: rtl/vvm_phase_avg.sv
// Deserializes vvm_dsp result frames, forms phase relative to channel 0 and
// smooths magnitude / relative phase per lane for the CSR readout.
//
//  state      | meaning
//  -----------+------------------------------------------------------------
//  ST_IDLE    | waiting for the first word of a frame
//  ST_COLLECT | capturing mag/phs words into the input buffer
//  ST_COMPUTE | one channel per cycle through the shared IIR datapath
//  ST_DONE    | latch output registers (unless hold), pulse valid_out
module vvm_phase_avg
    import vvm_pkg::*;
#(
    parameter int DW     = VVM_DW,
    parameter int N_CH   = 4,
    parameter int W_FRAC = W_FRAC_DEF
) (
    input  logic                 sample_clk,
    input  logic                 sample_rst_n,
    input  logic [DW-1:0]        stream_in,
    input  logic                 strobe_in,
    input  logic [3:0]           iir_shift,
    input  logic                 hold,
    input  logic                 err_clr,
    output logic [N_CH*DW-1:0]   mag_out,
    output logic [N_CH*DW-1:0]   phs_out,
    output logic                 valid_out,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int SW  = DW + W_FRAC;
    localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW  = CHW + 1;
    localparam logic [CW-1:0]  LAST_WORD = CW'(2*N_CH - 1);
    localparam logic [CHW-1:0] LAST_CH   = CHW'(N_CH - 1);

    fsm_state_t           state;
    logic [CW-1:0]        word_cnt;
    logic [CHW-1:0]       ch;
    logic [DW-1:0]        word_buf [2*N_CH];
    logic signed [SW-1:0] s_mag [N_CH];
    logic signed [SW-1:0] s_phs [N_CH];
    logic                 seed;
    logic                 burst_ign;

    logic [DW-1:0]        mag_x;
    logic [DW-1:0]        phs_x;
    logic signed [SW-1:0] mag_s_next;
    logic signed [SW-1:0] phs_s_next;
    logic                 fe_set;
    logic                 ov_set;

    assign fe_set = (state == ST_COLLECT) && !strobe_in;
    assign ov_set = strobe_in && ((state == ST_COMPUTE) || (state == ST_DONE));

    assign mag_x = word_buf[{ch, 1'b0}];
    assign phs_x = wrap_sub(word_buf[{ch, 1'b1}], word_buf[1]);

    wrap_iir_step #(.DW(DW), .W_FRAC(W_FRAC)) u_mag_step (
        .x        (mag_x),
        .s        (s_mag[ch]),
        .k        (iir_shift),
        .is_phase (1'b0),
        .seed     (seed),
        .s_next   (mag_s_next)
    );

    wrap_iir_step #(.DW(DW), .W_FRAC(W_FRAC)) u_phs_step (
        .x        (phs_x),
        .s        (s_phs[ch]),
        .k        (iir_shift),
        .is_phase (1'b1),
        .seed     (seed),
        .s_next   (phs_s_next)
    );

    always_ff @(posedge sample_clk or negedge sample_rst_n) begin
        if (!sample_rst_n) begin
            state     <= ST_IDLE;
            word_cnt  <= '0;
            ch        <= '0;
            seed      <= 1'b1;
            burst_ign <= 1'b0;
            valid_out <= 1'b0;
            mag_out   <= '0;
            phs_out   <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < 2*N_CH; i++) word_buf[i] <= '0;
            for (int n = 0; n < N_CH; n++) begin
                s_mag[n] <= '0;
                s_phs[n] <= '0;
            end
        end else begin
            valid_out <= 1'b0;
            frame_err <= fe_set | (frame_err & ~err_clr);
            overrun   <= ov_set | (overrun & ~err_clr);

            // a burst that collided with COMPUTE/DONE is skipped until strobe falls
            if (!strobe_in)  burst_ign <= 1'b0;
            else if (ov_set) burst_ign <= 1'b1;

            case (state)
                ST_IDLE: begin
                    if (strobe_in && !burst_ign) begin
                        word_buf[0] <= stream_in;
                        word_cnt    <= CW'(1);
                        state       <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!strobe_in) begin
                        state <= ST_IDLE;
                    end else begin
                        word_buf[word_cnt] <= stream_in;
                        if (word_cnt == LAST_WORD) begin
                            ch    <= '0;
                            state <= ST_COMPUTE;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    s_mag[ch] <= mag_s_next;
                    if (ch != '0) s_phs[ch] <= phs_s_next;
                    if (ch == LAST_CH) begin
                        seed  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (!hold) begin
                        valid_out        <= 1'b1;
                        phs_out[DW-1:0]  <= word_buf[1];
                        for (int n = 0; n < N_CH; n++)
                            mag_out[n*DW +: DW] <= s_mag[n][SW-1:W_FRAC];
                        for (int n = 1; n < N_CH; n++)
                            phs_out[n*DW +: DW] <= s_phs[n][SW-1:W_FRAC];
                    end
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vvm_phase_avg.sv
// Scoreboard bench for vvm_phase_avg: directed frames from the test plan plus
// random frames checked against an arithmetic model of the smoothing rules.
module tb_vvm_phase_avg;

    localparam int DW     = 21;
    localparam int N_CH   = 4;
    localparam int W_FRAC = 15;
    localparam int SW     = DW + W_FRAC;
    localparam int LW     = N_CH * DW;
    localparam longint FULL_S = 64'sd1 <<< SW;
    localparam longint FULL_D = 64'sd1 <<< DW;

    logic            sample_clk = 1'b0;
    logic            sample_rst_n = 1'b0;
    logic [DW-1:0]   stream_in = '0;
    logic            strobe_in = 1'b0;
    logic [3:0]      iir_shift = '0;
    logic            hold = 1'b0;
    logic            err_clr = 1'b0;
    logic [LW-1:0]   mag_out;
    logic [LW-1:0]   phs_out;
    logic            valid_out;
    logic            frame_err;
    logic            overrun;

    vvm_phase_avg #(.DW(DW), .N_CH(N_CH), .W_FRAC(W_FRAC)) dut (
        .sample_clk   (sample_clk),
        .sample_rst_n (sample_rst_n),
        .stream_in    (stream_in),
        .strobe_in    (strobe_in),
        .iir_shift    (iir_shift),
        .hold         (hold),
        .err_clr      (err_clr),
        .mag_out      (mag_out),
        .phs_out      (phs_out),
        .valid_out    (valid_out),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 sample_clk = ~sample_clk;

    int cyc = 0;
    always @(posedge sample_clk) cyc++;

    typedef struct {
        logic [LW-1:0] mag;
        logic [LW-1:0] phs;
        int            due;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [LW-1:0] act,
                                  input logic [LW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [DW-1:0] dwv(input int v);
        logic [31:0] t;
        t = v;
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] lane(input logic [LW-1:0] v, input int n);
        return v[n*DW +: DW];
    endfunction

    // ---------------- reference model ----------------
    longint        m_mag [N_CH];
    longint        m_phs [N_CH];
    bit            m_seed;
    logic [LW-1:0] m_out_mag;
    logic [LW-1:0] m_out_phs;

    function automatic longint wrap_mod(input longint v, input longint full);
        longint m;
        m = v % full;
        if (m < 0) m += full;
        if (m >= full / 2) m -= full;
        return m;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < N_CH; n++) begin
            m_mag[n] = 0;
            m_phs[n] = 0;
        end
        m_seed    = 1'b1;
        m_out_mag = '0;
        m_out_phs = '0;
    endtask

    task automatic model_frame(input int mags[N_CH], input int phs[N_CH], input int k,
                               input bit hld, input int due);
        int   kk;
        exp_t e;
        kk = (k > W_FRAC) ? W_FRAC : k;
        for (int n = 0; n < N_CH; n++) begin
            longint xm;
            longint xp;
            xm = longint'(mags[n]) * 32768;
            m_mag[n] = m_seed ? xm : m_mag[n] + ((xm - m_mag[n]) >>> kk);
            if (n > 0) begin
                xp = wrap_mod(longint'(phs[n]) - longint'(phs[0]), FULL_D) * 32768;
                m_phs[n] = m_seed ? xp
                                  : wrap_mod(m_phs[n] + (wrap_mod(xp - m_phs[n], FULL_S) >>> kk), FULL_S);
            end
        end
        m_seed = 1'b0;
        if (!hld) begin
            for (int n = 0; n < N_CH; n++) begin
                longint om;
                longint op;
                om = m_mag[n] >>> W_FRAC;
                op = m_phs[n] >>> W_FRAC;
                m_out_mag[n*DW +: DW] = om[DW-1:0];
                m_out_phs[n*DW +: DW] = (n == 0) ? dwv(phs[0]) : op[DW-1:0];
            end
            e.mag = m_out_mag;
            e.phs = m_out_phs;
            e.due = due;
            sb.push_back(e);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge sample_clk) begin
        exp_t e;
        if (sample_rst_n && valid_out) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: valid_out at cycle %0d, expected none", cyc);
            end else begin
                e = sb.pop_front();
                check("mag_out", mag_out, e.mag);
                check("phs_out", phs_out, e.phs);
                check("valid_cycle", LW'(cyc), LW'(e.due));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(posedge sample_clk);
        #1;
    endtask

    task automatic send_words(input int mags[N_CH], input int phs[N_CH], input int n_words,
                              input int k, input bit hld, output int last);
        int v;
        last = cyc;
        for (int i = 0; i < n_words; i++) begin
            @(posedge sample_clk);
            #1;
            if (i == 0) begin
                iir_shift = 4'(k);
                hold      = hld;
            end
            v = (i % 2 == 0) ? mags[i/2] : phs[i/2];
            stream_in = dwv(v);
            strobe_in = 1'b1;
            last      = cyc;
        end
        @(posedge sample_clk);
        #1;
        strobe_in = 1'b0;
        stream_in = '0;
    endtask

    // gap = number of strobe-low cycles before the next frame may start
    task automatic frame(input int mags[N_CH], input int phs[N_CH], input int k,
                         input bit hld, input int gap);
        int last;
        send_words(mags, phs, 2*N_CH, k, hld, last);
        model_frame(mags, phs, k, hld, last + N_CH + 2);
        idle(gap - 1);
    endtask

    task automatic do_reset();
        sample_rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge sample_clk);
        #1;
        sample_rst_n = 1'b1;
    endtask

    task automatic pulse_err_clr();
        @(posedge sample_clk);
        #1 err_clr = 1'b1;
        @(posedge sample_clk);
        #1 err_clr = 1'b0;
    endtask

    initial begin
        int mg[N_CH];
        int ph[N_CH];
        int iir_exp[4];
        int last;
        logic [LW-1:0] keep_mag;
        logic [LW-1:0] keep_phs;

        model_reset();
        repeat (3) @(posedge sample_clk);
        #1 sample_rst_n = 1'b1;

        check("reset_mag", mag_out, '0);
        check("reset_phs", phs_out, '0);
        check("reset_valid", LW'(valid_out), '0);
        check("reset_frame_err", LW'(frame_err), '0);
        check("reset_overrun", LW'(overrun), '0);

        // passthrough, relative phase
        mg = '{1000, 2000, 3000, 4000};
        ph = '{100, 699151, 100, -100};
        frame(mg, ph, 0, 1'b0, N_CH + 1);
        idle(2);
        check("pass_mag0", LW'(lane(mag_out, 0)), LW'(dwv(1000)));
        check("pass_mag3", LW'(lane(mag_out, 3)), LW'(dwv(4000)));
        check("pass_phs0", LW'(lane(phs_out, 0)), LW'(dwv(100)));
        check("pass_phs1", LW'(lane(phs_out, 1)), LW'(dwv(699051)));
        check("pass_phs2", LW'(lane(phs_out, 2)), LW'(dwv(0)));
        check("pass_phs3", LW'(lane(phs_out, 3)), LW'(dwv(-200)));

        // wrap across +/-pi
        mg = '{10, 20, 30, 40};
        ph = '{1048000, -1048000, 0, 0};
        frame(mg, ph, 0, 1'b0, N_CH + 1);
        idle(2);
        check("wrap_k0_phs1", LW'(lane(phs_out, 1)), LW'(dwv(1152)));
        for (int r = 0; r < 3; r++) begin
            frame(mg, ph, 3, 1'b0, N_CH + 1);
            idle(2);
            check("wrap_k3_phs1", LW'(lane(phs_out, 1)), LW'(dwv(1152)));
        end

        // IIR step response, k=2, seeded from zero
        do_reset();
        mg = '{0, 0, 0, 0};
        ph = '{0, 0, 0, 0};
        frame(mg, ph, 2, 1'b0, N_CH + 1);
        idle(2);
        check("iir_seed_mag0", LW'(lane(mag_out, 0)), '0);
        iir_exp = '{256, 448, 592, 700};
        mg = '{1024, 1024, 1024, 1024};
        for (int r = 0; r < 4; r++) begin
            frame(mg, ph, 2, 1'b0, N_CH + 1);
            idle(2);
            check("iir_step_mag0", LW'(lane(mag_out, 0)), LW'(dwv(iir_exp[r])));
        end

        // strobe drops after word 5
        keep_mag = m_out_mag;
        keep_phs = m_out_phs;
        mg = '{7, 8, 9, 10};
        ph = '{11, 12, 13, 14};
        send_words(mg, ph, 5, 2, 1'b0, last);
        idle(N_CH + 3);
        check("frame_err_set", LW'(frame_err), LW'(1'b1));
        check("frame_err_mag_kept", mag_out, keep_mag);
        check("frame_err_phs_kept", phs_out, keep_phs);
        pulse_err_clr();
        check("frame_err_clr", LW'(frame_err), '0);

        // second frame starts during COMPUTE of the first
        mg = '{300, 400, 500, 600};
        ph = '{-5000, 6000, 70000, -80000};
        frame(mg, ph, 1, 1'b0, 1);
        mg = '{9999, 9999, 9999, 9999};
        send_words(mg, ph, 2*N_CH, 1, 1'b0, last);
        idle(N_CH + 3);
        check("overrun_set", LW'(overrun), LW'(1'b1));
        check("overrun_mag", mag_out, m_out_mag);
        pulse_err_clr();
        check("overrun_clr", LW'(overrun), '0);
        mg = '{1500, 2500, 3500, 4500};
        frame(mg, ph, 1, 1'b0, N_CH + 1);
        idle(2);

        // hold freezes outputs while the IIR advances
        keep_mag = mag_out;
        keep_phs = phs_out;
        mg = '{80000, 90000, 100000, 110000};
        ph = '{1000, 2000, 3000, 4000};
        frame(mg, ph, 1, 1'b1, N_CH + 1);
        idle(2);
        check("hold_mag_kept", mag_out, keep_mag);
        check("hold_phs_kept", phs_out, keep_phs);
        frame(mg, ph, 1, 1'b0, N_CH + 1);
        idle(2);

        // reset during COMPUTE
        mg = '{123, 456, 789, 1011};
        send_words(mg, ph, 2*N_CH, 4, 1'b0, last);
        @(posedge sample_clk);
        #1 sample_rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_mid_mag", mag_out, '0);
        check("rst_mid_phs", phs_out, '0);
        @(posedge sample_clk);
        #1 sample_rst_n = 1'b1;
        idle(N_CH + 3);
        check("rst_mid_mag_after", mag_out, '0);
        mg = '{500, 500, 500, 500};
        frame(mg, ph, 4, 1'b0, N_CH + 1);
        idle(2);
        check("rst_reseed_mag0", LW'(lane(mag_out, 0)), LW'(dwv(500)));

        // random frames
        for (int r = 0; r < 40; r++) begin
            int  k;
            bit  hld;
            for (int n = 0; n < N_CH; n++) begin
                mg[n] = int'($urandom_range(0, (1 << (DW-1)) - 1));
                ph[n] = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW-1));
            end
            k   = int'($urandom_range(0, 15));
            hld = ($urandom_range(0, 5) == 0);
            frame(mg, ph, k, hld, N_CH + 1 + int'($urandom_range(0, 3)));
        end

        idle(N_CH + 6);
        check("scoreboard_drain", LW'(sb.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
